// File: rtl/alu_pkg.sv
// alu_pkg: types and constants shared between the ALU and its issue logic.
//   op_type_t   - 3-bit ALU operation encoding (codes 6 and 7 are undefined)
//   ALU_LAT     - number of register stages between ALU inputs and its output
//   op_is_valid - true for the defined op codes
package alu_pkg;

   typedef enum logic [2:0] {
      OpNop = 3'd0,
      OpAdd = 3'd1,
      OpSub = 3'd2,
      OpAnd = 3'd3,
      OpOr  = 3'd4,
      OpSlt = 3'd5
   } op_type_t;

   localparam int unsigned ALU_LAT = 2;

   function automatic logic op_is_valid(logic [2:0] op);
      return op <= 3'd5;
   endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: synchronous circular-buffer FIFO for tagged ALU responses.
// DEPTH need not be a power of two; pointers wrap explicitly at DEPTH-1.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   push_i      - write data_i this cycle (caller guarantees not full)
//   data_i      - entry to write
//   pop_i       - consume head this cycle (ignored when empty)
//   count_o     - current occupancy
//   head_o      - oldest entry, zero when empty
module alu_rsp_fifo #(
   parameter int unsigned DW    = 36,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_i,
   input  logic [DW-1:0]   data_i,
   input  logic            pop_i,
   output logic [CntW-1:0] count_o,
   output logic [DW-1:0]   head_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0]   mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign count_o = count_q;
   assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({push_i, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: head_o is masked while empty.
   always_ff @(posedge clk) begin
      if (rst_n && push_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // The issuer's credit check must make overflow impossible.
   always_ff @(posedge clk) begin
      if (rst_n && push_i) begin
         assert (count_q != CntW'(DEPTH));
      end
   end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: initiator side of the two-stage registered ALU interface.
// Accepts tagged requests, drives the ALU, tracks its fixed latency with a
// valid/tag shift pipeline, queues results in a credit-protected FIFO and
// returns them in request order.
// Ports:
//   clk, rst_n                    - clock, synchronous active-low reset
//   req_valid/req_ready           - request handshake
//   req_op/req_a/req_b/req_tag    - request payload
//   alu_op/alu_a/alu_b            - to the ALU (NOP/0 when nothing issued)
//   alu_result                    - ALU output, ALU_LAT cycles after issue
//   rsp_valid/rsp_ready           - response handshake
//   rsp_data/rsp_tag              - response payload
//   rsp_err                       - only with ALU_ISSUE_ERR_EN: request op was 6/7
// Macro ALU_ISSUE_ERR_EN adds rsp_err and per-entry error storage.
module alu_issue
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [TAG_W-1:0] req_tag,
   output op_type_t         alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [TAG_W-1:0] rsp_tag
`ifdef ALU_ISSUE_ERR_EN
   ,
   output logic             rsp_err
`endif
);

   localparam int unsigned LastStg = ALU_LAT - 1;
   localparam int unsigned CntW    = $clog2(DEPTH + 1);
   localparam int unsigned OccW    = $clog2(DEPTH + ALU_LAT + 1);
`ifdef ALU_ISSUE_ERR_EN
   localparam int unsigned DW      = WIDTH + TAG_W + 1;
`else
   localparam int unsigned DW      = WIDTH + TAG_W;
`endif

   logic               accept;
   logic               op_ok;
   logic [ALU_LAT-1:0] v_q, v_d;
   logic [TAG_W-1:0]   t_q [ALU_LAT];
   logic [TAG_W-1:0]   t_d [ALU_LAT];
   logic [CntW-1:0]    fifo_count;
   logic [OccW-1:0]    occ;
   logic [DW-1:0]      push_data;
   logic [DW-1:0]      head;

   assign op_ok  = op_is_valid(req_op);
   assign accept = req_valid && req_ready;

   // Credit: everything in flight plus queued must fit in the FIFO. A pop in
   // the same cycle is deliberately not credited.
   always_comb begin
      occ = OccW'(fifo_count);
      for (int i = 0; i < ALU_LAT; i++) begin
         occ = occ + OccW'(v_q[i]);
      end
      req_ready = rst_n && (occ < OccW'(DEPTH));
   end

   always_comb begin
      alu_op = OpNop;
      alu_a  = '0;
      alu_b  = '0;
      if (accept) begin
         alu_op = op_ok ? op_type_t'(req_op) : OpNop;
         alu_a  = req_a;
         alu_b  = req_b;
      end
   end

   // Latency tracker: stage i holds the request issued i+1 edges ago.
   always_comb begin
      v_d    = v_q;
      t_d    = t_q;
      v_d[0] = accept;
      if (accept) begin
         t_d[0] = req_tag;
      end
      for (int i = 1; i < ALU_LAT; i++) begin
         v_d[i] = v_q[i-1];
         t_d[i] = t_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q <= '0;
         t_q <= '{default: '0};
      end else begin
         v_q <= v_d;
         t_q <= t_d;
      end
   end

`ifdef ALU_ISSUE_ERR_EN
   logic [ALU_LAT-1:0] e_q, e_d;

   always_comb begin
      e_d    = e_q;
      e_d[0] = accept && !op_ok;
      for (int i = 1; i < ALU_LAT; i++) begin
         e_d[i] = e_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         e_q <= '0;
      end else begin
         e_q <= e_d;
      end
   end

   assign push_data = {e_q[LastStg], t_q[LastStg], alu_result};
   assign rsp_err   = head[DW-1];
`else
   assign push_data = {t_q[LastStg], alu_result};
`endif

   alu_rsp_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (v_q[LastStg]),
      .data_i  (push_data),
      .pop_i   (rsp_ready),
      .count_o (fifo_count),
      .head_o  (head)
   );

   assign rsp_valid = (fifo_count != '0);
   assign rsp_data  = head[WIDTH-1:0];
   assign rsp_tag   = head[WIDTH +: TAG_W];

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue with a behavioural
// two-stage registered ALU attached to the alu_* ports.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_tag;
   logic [2:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_tag;
`ifdef ALU_ISSUE_ERR_EN
   logic        rsp_err;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_issue #(
      .WIDTH (32),
      .TAG_W (4),
      .DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_tag    (req_tag),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_tag    (rsp_tag)
`ifdef ALU_ISSUE_ERR_EN
      ,
      .rsp_err    (rsp_err)
`endif
   );

   // Two-stage registered ALU; its reset is ~rst_n (active high, synchronous).
   logic [2:0]  s_op;
   logic [31:0] s_a, s_b;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_op       <= 3'd0;
         s_a        <= '0;
         s_b        <= '0;
         alu_result <= '0;
      end else begin
         s_op <= alu_op;
         s_a  <= alu_a;
         s_b  <= alu_b;
         case (s_op)
            3'd1:    alu_result <= s_a + s_b;
            3'd2:    alu_result <= s_a - s_b;
            3'd3:    alu_result <= s_a & s_b;
            3'd4:    alu_result <= s_a | s_b;
            3'd5:    alu_result <= ($signed(s_a) < $signed(s_b)) ? 32'd1 : 32'd0;
            default: alu_result <= '0;
         endcase
      end
   end

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      req_op    = 3'd0;
      req_a     = '0;
      req_b     = '0;
      req_tag   = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
      checks++; if (rsp_tag !== 4'd0) begin errors++; $display("FAIL reset_rsp_tag got=%h want=0", rsp_tag); end
      checks++; if (alu_op !== 3'd0) begin errors++; $display("FAIL reset_alu_op got=%0d want=0", alu_op); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready got=%b want=1", req_ready); end
   endtask

   task automatic test_single_add();
      @(negedge clk);
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_op = 3'd1; req_a = 32'd5; req_b = 32'd7; req_tag = 4'd3;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL add_req_ready got=%b want=1", req_ready); end
      checks++; if (alu_op !== 3'd1) begin errors++; $display("FAIL add_alu_op got=%0d want=1", alu_op); end
      checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin
         errors++; $display("FAIL add_alu_ab got=%0d,%0d want=5,7", alu_a, alu_b);
      end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checks++; if (alu_op !== 3'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
         errors++; $display("FAIL idle_alu got=%0d,%0d,%0d want=0,0,0", alu_op, alu_a, alu_b);
      end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early1 got=%b want=0", rsp_valid); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early2 got=%b want=0", rsp_valid); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid got=%b want=1", rsp_valid); end
      checks++; if (rsp_data !== 32'd12) begin errors++; $display("FAIL add_rsp_data got=%0d want=12", rsp_data); end
      checks++; if (rsp_tag !== 4'd3) begin errors++; $display("FAIL add_rsp_tag got=%0d want=3", rsp_tag); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_after got=%b want=0", rsp_valid); end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  ops [4];
      logic [31:0] as  [4];
      logic [31:0] bs  [4];
      logic [31:0] exp [4];
      ops = '{3'd2, 3'd3, 3'd4, 3'd5};
      as  = '{32'd10, 32'hF0, 32'hF0, 32'd1};
      bs  = '{32'd3, 32'h3C, 32'h0F, 32'd2};
      exp = '{32'd7, 32'h30, 32'hFF, 32'd1};
      rsp_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c < 4) begin
            req_valid = 1'b1; req_op = ops[c]; req_a = as[c]; req_b = bs[c]; req_tag = 4'(c);
         end else begin
            req_valid = 1'b0;
         end
         #1;
         if (c < 4) begin
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c=%0d got=%b want=1", c, req_ready); end
         end
         if (c >= 3 && c < 7) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp[c-3] || rsp_tag !== 4'(c - 3)) begin
               errors++;
               $display("FAIL b2b_rsp c=%0d got=%b/%h/%0d want=1/%h/%0d", c, rsp_valid, rsp_data, rsp_tag,
                        exp[c-3], c - 3);
            end
         end
         if (c == 7) begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail got=%b want=0", rsp_valid); end
         end
      end
   endtask

   task automatic test_backpressure();
      int sent = 0;
      rsp_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         req_valid = 1'b1; req_op = 3'd1; req_a = 32'(sent); req_b = 32'd100; req_tag = 4'(sent + 4);
         #1;
         if (req_ready) sent++;
      end
      checks++; if (sent != 4) begin errors++; $display("FAIL bp_accepts got=%0d want=4", sent); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b want=0", req_ready); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         #1;
         checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd100 || rsp_tag !== 4'd4) begin
            errors++; $display("FAIL bp_hold got=%b/%0d/%0d want=1/100/4", rsp_valid, rsp_data, rsp_tag);
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rsp_ready = 1'b1;
         #1;
         checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'(100 + i) || rsp_tag !== 4'(4 + i)) begin
            errors++;
            $display("FAIL bp_drain i=%0d got=%b/%0d/%0d want=1/%0d/%0d", i, rsp_valid, rsp_data, rsp_tag,
                     100 + i, 4 + i);
         end
      end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b want=0", rsp_valid); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%b want=1", req_ready); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_d [$];
      logic [3:0]  exp_t [$];
      logic [31:0] ed;
      logic [3:0]  et;
      int          sent = 0;
      int          got  = 0;
      for (int cyc = 0; cyc < 200 && got < 12; cyc++) begin
         @(negedge clk);
         rsp_ready = (cyc % 3) != 2;
         if (sent < 12) begin
            req_valid = 1'b1; req_op = 3'd1;
            req_a = 32'(sent * 16); req_b = 32'(sent); req_tag = 4'(sent);
         end else begin
            req_valid = 1'b0;
         end
         #1;
         if (req_valid && req_ready) begin
            exp_d.push_back(32'(sent * 17));
            exp_t.push_back(4'(sent));
            sent++;
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_d.size() == 0) begin
               checks++; errors++;
               $display("FAIL wrap_spurious got=%0d/%0d want=none", rsp_data, rsp_tag);
            end else begin
               ed = exp_d.pop_front();
               et = exp_t.pop_front();
               checks++; if (rsp_data !== ed) begin errors++; $display("FAIL wrap_data got=%0d want=%0d", rsp_data, ed); end
               checks++; if (rsp_tag !== et) begin errors++; $display("FAIL wrap_tag got=%0d want=%0d", rsp_tag, et); end
               got++;
            end
         end
      end
      checks++; if (got != 12) begin errors++; $display("FAIL wrap_count got=%0d want=12", got); end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wrap_tail got=%b want=0", rsp_valid); end
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req_valid = 1'b1; req_op = 3'd1; req_a = 32'(i); req_b = 32'd50; req_tag = 4'(10 + i);
         #1;
         checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready i=%0d got=%b want=1", i, req_ready); end
      end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_queued got=%b want=1", rsp_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_rst got=%b want=0", req_ready); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_flush got=%b want=0", rsp_valid); end
      rst_n = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_release got=%b want=1", req_ready); end
      rsp_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale c=%0d got=%b want=0", c, rsp_valid); end
      end
   endtask

   task automatic test_invalid_op();
      @(negedge clk);
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_op = 3'd7; req_a = 32'd3; req_b = 32'd4; req_tag = 4'd9;
      #1;
      checks++; if (req_ready !== 1'b1 || alu_op !== 3'd0) begin
         errors++; $display("FAIL inv_alu_op got=%b/%0d want=1/0", req_ready, alu_op);
      end
      @(negedge clk);
      req_op = 3'd1; req_a = 32'd2; req_b = 32'd3; req_tag = 4'd5;
      #1;
      checks++; if (alu_op !== 3'd1) begin errors++; $display("FAIL inv_next_op got=%0d want=1", alu_op); end
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_tag !== 4'd9) begin
         errors++; $display("FAIL inv_rsp got=%b/%0d/%0d want=1/0/9", rsp_valid, rsp_data, rsp_tag);
      end
`ifdef ALU_ISSUE_ERR_EN
      checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL inv_err got=%b want=1", rsp_err); end
`endif
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd5 || rsp_tag !== 4'd5) begin
         errors++; $display("FAIL inv_adj got=%b/%0d/%0d want=1/5/5", rsp_valid, rsp_data, rsp_tag);
      end
`ifdef ALU_ISSUE_ERR_EN
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL inv_adj_err got=%b want=0", rsp_err); end
`endif
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL inv_tail got=%b want=0", rsp_valid); end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_back_to_back();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      test_invalid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Initiator side of the two-stage registered ALU interface.
- Accepts tagged operation requests on a valid/ready channel and drives op/a/b to the ALU.
- Tracks the fixed ALU latency with a valid/tag shift pipeline, captures results into a credit-protected response FIFO, and returns tagged results on a valid/ready channel.
- Sits between decode/execute control and the ALU instance.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- TAG_W, 4, request tag width.
- DEPTH, 4, response FIFO entries; minimum 1; back-to-back throughput requires at least 4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset. The parent drives the ALU reset with ~rst_n.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_op  in  3  op_type_t encoding (NOP=0, ADD=1, SUB=2, AND=3, OR=4, SLT=5).
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_tag  in  TAG_W  tag returned with the result.
- alu_op  out  3  to ALU op_in.
- alu_a  out  WIDTH  to ALU a_in.
- alu_b  out  WIDTH  to ALU b_in.
- alu_result  in  WIDTH  from ALU out.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_data  out  WIDTH  result.
- rsp_tag  out  TAG_W  tag of the result.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values: rsp_valid=0, req_ready=0 during reset, FIFO empty, pipeline valids v0=v1=0, tags 0, rsp_data/rsp_tag=0.
- Issue (combinational):
  - accept = req_valid && req_ready.
  - When accept: alu_op/alu_a/alu_b = req_op/req_a/req_b.
  - Otherwise: alu_op=NOP, alu_a=alu_b=0.
  - req_ready must not depend on req_valid.
- Credit rule: req_ready = rst_n && (v0 + v1 + fifo_count) < DEPTH.
  - A same-cycle pop is NOT credited; this is conservative and intentional.
- Pipeline:
  - Edge E0 (accept): v0<=1, t0<=req_tag.
  - E1: v1<=v0, t1<=t0.
  - E2: if v1, push {alu_result, t1} into the FIFO.
  - rsp_valid first rises the cycle after E2, i.e. 2 cycles after the accept edge.
- FIFO:
  - Circular buffer; pointers wrap at DEPTH. DEPTH need not be a power of two; compare and reset pointers explicitly.
  - rsp_data/rsp_tag = head entry, stable while rsp_valid && !rsp_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push while full cannot occur, guaranteed by the credit rule; assert on it in simulation.
- Ordering: responses return strictly in request order.
- Invalid op (6 or 7): issued to the ALU as NOP; the response returns result 0 with the request's tag.
- Reset mid-operation: all in-flight pipeline entries and FIFO contents are discarded; no response is produced for them.

Optional Feature:
- Macro ALU_ISSUE_ERR_EN.
- When defined:
  - Adds output rsp_err (1 bit), stored per FIFO entry and carried through v0/v1.
  - rsp_err=1 for responses whose request op was 6 or 7; reset value 0.
- When undefined: no rsp_err port and no error storage; invalid ops are silently converted to NOP.

Decomposition:
- Package alu_pkg holds op_type_t, shared with the ALU, and localparam ALU_LAT=2.
- The pipeline depth is derived from ALU_LAT.
- One sub-module: alu_rsp_fifo, a parameterized WIDTH+TAG_W(+1) synchronous FIFO exposing count, push, pop and head.

Test Plan:
- Reset then single ADD a=5, b=7, tag=3, rsp_ready=1 → rsp_valid 2 cycles after accept, rsp_data=12, rsp_tag=3, then rsp_valid=0.
- Back-to-back SUB 10-3, AND 0xF0&0x3C, OR 0xF0|0x0F, SLT 1,2 on tags 0..3 with rsp_ready=1, DEPTH=4 → req_ready stays 1; responses 7, 0x30, 0xFF, 1 in order on consecutive cycles.
- rsp_ready=0 while streaming ADDs → req_ready drops after 4 accepts; no loss; releasing rsp_ready drains all 4 in order with correct tags.
- Hold rsp_ready=0 with rsp_valid=1 → rsp_data/rsp_tag unchanged; then a push and a pop in the same cycle → count constant, order preserved across pointer wrap after more than 8 transactions.
- rst_n low one cycle with 2 requests in flight and 1 queued → rsp_valid=0 next cycle, req_ready=1 after release, no stale responses.
- op=7, tag=9 → alu_op=NOP, response data=0, tag=9; with ALU_ISSUE_ERR_EN, rsp_err=1, and rsp_err=0 on an adjacent valid ADD.
